// File: rtl/local_sp_mem_arbiter.sv
// Arbiter sharing one single-port local buffer between a loader write port and a
// compute read port, with read-response tracking and a zero-fill sequencer.
module local_sp_mem_arbiter #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AddressWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0]    wr_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [AddressWidth-1:0] rd_addr,
    output logic                    rd_rsp_valid,
    output logic [DataWidth-1:0]    rd_rsp_data,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic                    clear_done,
    output logic [AddressWidth-1:0] mem_address0,
    output logic                    mem_ce0,
    output logic                    mem_we0,
    output logic [DataWidth-1:0]    mem_d0,
    input  logic [DataWidth-1:0]    mem_q0,
    output logic                    dbg_state
);

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int TagDepth = 1 + READ_LATENCY;
    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

    state_e                  state_q, state_d;
    logic                    rr_q, rr_d;  // 0: read wins under contention, 1: write wins
    logic [AddressWidth-1:0] cnt_q, cnt_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]    data_q, data_d;
    logic                    ce_q, ce_d;
    logic                    we_q, we_d;
    logic                    done_q, done_d;
    logic [TagDepth-1:0]     tag_q, tag_d;
    logic                    wr_grant, rd_grant;
    logic                    rd_accept;

    // Handshake: a request transfers on a cycle where valid and ready are both high;
    // ready is the combinational grant, so it never rises without valid.
    assign wr_ready  = wr_grant & reset;
    assign rd_ready  = rd_grant & reset;
    assign rd_accept = rd_ready;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ce_d     = 1'b0;
        we_d     = 1'b0;
        done_d   = 1'b0;
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        unique case (state_q)
            SERVE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (wr_valid && rd_valid) begin
                        rd_grant = ~rr_q;
                        wr_grant = rr_q;
                        rr_d     = ~rr_q;
                    end else begin
                        rd_grant = rd_valid;
                        wr_grant = wr_valid;
                    end
                    if (rd_grant) begin
                        ce_d   = 1'b1;
                        addr_d = rd_addr;
                    end else if (wr_grant) begin
                        ce_d   = 1'b1;
                        we_d   = 1'b1;
                        addr_d = wr_addr;
                        data_d = wr_data;
                    end
                end
            end
            CLEAR: begin
                ce_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + AddressWidth'(1);
                if (cnt_q == LastAddr) begin
                    done_d  = 1'b1;
                    state_d = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    // Tag pipeline runs regardless of state so reads issued before a clear still return.
    assign tag_d = {tag_q[TagDepth-2:0], rd_accept};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SERVE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            done_q  <= done_d;
            tag_q   <= tag_d;
        end
    end

    assign mem_address0 = addr_q;
    assign mem_ce0      = ce_q;
    assign mem_we0      = we_q;
    assign mem_d0       = data_q;
    assign clear_done   = done_q;
    assign clear_busy   = (state_q == CLEAR);
    assign rd_rsp_valid = tag_q[TagDepth-1];
    assign rd_rsp_data  = mem_q0;
    assign dbg_state    = state_q;

endmodule
